// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD -> Excess-K stream converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Converter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_excess_digit.sv
// Single-digit Excess-K encoder/decoder; flags digits outside the legal range.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module bcd_excess_digit
    import bcd_pkg::*;
#(
    parameter int OFFSET = 6
) (
    input  logic [DIGIT_W-1:0] digit,
    input  logic               mode,
    output logic [DIGIT_W-1:0] code,
    output logic               err
);

    // 5-bit arithmetic so that 9+OFFSET (up to 15) and comparisons never wrap
    localparam logic [DIGIT_W-1:0] OFF4    = DIGIT_W'(OFFSET);
    localparam logic [DIGIT_W:0]   OFF5    = (DIGIT_W+1)'(OFFSET);
    localparam logic [DIGIT_W:0]   MAXOFF5 = {1'b0, BCD_MAX} + OFF5;

    logic [DIGIT_W:0] c5;
    logic [DIGIT_W:0] dec5;

    assign c5   = {1'b0, digit};
    assign dec5 = c5 - OFF5;

    // Encode adds OFFSET to a valid BCD digit; decode strips it from a valid code
    always_comb begin
        code = '0;
        err  = 1'b0;
        if (mode) begin
            if ((c5 >= OFF5) && (c5 <= MAXOFF5)) begin
                code = dec5[DIGIT_W-1:0];
            end else begin
                err = 1'b1;
            end
        end else begin
            if (digit <= BCD_MAX) begin
                code = digit + OFF4;
            end else begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_excess_stream.sv
// Multi-digit handshaked BCD -> Excess-K converter, one digit per clock, LSB digit first.
// Latency: word accepted at edge 0, out_valid after edge NDIGITS; words spaced >= NDIGITS+2 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Optional decode path (mode port) enabled by defining BCD_EXCESS_DECODE_EN.
module bcd_excess_stream
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int OFFSET  = 6,
    localparam int DW     = DIGIT_W * NDIGITS
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef BCD_EXCESS_DECODE_EN
    input  logic               mode,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_bcd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_code,
    output logic [NDIGITS-1:0] out_err,
    output logic               busy
);

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    if ((OFFSET < 0) || (OFFSET > 6)) begin : g_bad_offset
        $error("bcd_excess_stream: OFFSET must be in 0..6");
    end
    if (NDIGITS < 1) begin : g_bad_ndigits
        $error("bcd_excess_stream: NDIGITS must be >= 1");
    end

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        shift_q, shift_d;
    logic [DW-1:0]        code_q, code_d;
    logic [NDIGITS-1:0]   err_q, err_d;
    logic                 dig_mode;
    logic [DIGIT_W-1:0]   dig_code;
    logic                 dig_err;

`ifdef BCD_EXCESS_DECODE_EN
    logic                 mode_q, mode_d;
    assign dig_mode = mode_q;
`else
    assign dig_mode = 1'b0;
`endif

    // One converter shared over time; the shift register presents the current digit at its bottom
    bcd_excess_digit #(
        .OFFSET (OFFSET)
    ) u_digit (
        .digit (shift_q[DIGIT_W-1:0]),
        .mode  (dig_mode),
        .code  (dig_code),
        .err   (dig_err)
    );

    // Next-state: accept in IDLE, convert one digit per cycle in CONV, hold result in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        code_d  = code_q;
        err_d   = err_q;
`ifdef BCD_EXCESS_DECODE_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_bcd;
                    cnt_d   = '0;
                    code_d  = '0;
                    err_d   = '0;
`ifdef BCD_EXCESS_DECODE_EN
                    mode_d  = mode;
`endif
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                code_d[DIGIT_W*int'(cnt_q) +: DIGIT_W] = dig_code;
                err_d[cnt_q] = dig_err;
                shift_d = shift_q >> DIGIT_W;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            err_q   <= '0;
`ifdef BCD_EXCESS_DECODE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            err_q   <= err_d;
`ifdef BCD_EXCESS_DECODE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_code  = code_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_excess_stream.sv
// Directed bench for bcd_excess_stream: vector table plus backpressure, reset and 1-digit cases.
// Latency: n/a.
// Backpressure: exercised via out_ready held low in DONE.
module tb_bcd_excess_stream;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_code;
    logic [3:0]  out_err;
    logic        busy;

    logic        in1_valid;
    logic        in1_ready;
    logic [3:0]  in1_bcd;
    logic        out1_valid;
    logic        out1_ready;
    logic [3:0]  out1_code;
    logic [0:0]  out1_err;
    logic        busy1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] code;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs [8];

    bcd_excess_stream #(.NDIGITS(4), .OFFSET(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BCD_EXCESS_DECODE_EN
        .mode      (mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .busy      (busy)
    );

    bcd_excess_stream #(.NDIGITS(1), .OFFSET(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BCD_EXCESS_DECODE_EN
        .mode      (1'b0),
`endif
        .in_valid  (in1_valid),
        .in_ready  (in1_ready),
        .in_bcd    (in1_bcd),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_code  (out1_code),
        .out_err   (out1_err),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a word in IDLE, time the result, compare, then release it.
    task automatic run_word(input string name, input logic [15:0] bcd,
                            input logic [15:0] exp_code, input logic [3:0] exp_err);
        int lat;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_bcd   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hDEAD;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_code"}, 32'(out_code), 32'(exp_code));
        chk({name, "_err"}, 32'(out_err), 32'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{16'h2899, 16'h8EFF, 4'b0000};
        vecs[1] = '{16'h00F1, 16'h6607, 4'b0010};
        vecs[2] = '{16'h0000, 16'h6666, 4'b0000};
        vecs[3] = '{16'h9999, 16'hFFFF, 4'b0000};
        vecs[4] = '{16'hFFFF, 16'h0000, 4'b1111};
        vecs[5] = '{16'h1234, 16'h789A, 4'b0000};
        vecs[6] = '{16'hA5B0, 16'h0B06, 4'b1010};
        vecs[7] = '{16'h5678, 16'hBCDE, 4'b0000};

        mode       = 1'b0;
        in_valid   = 1'b0;
        in_bcd     = '0;
        out_ready  = 1'b0;
        in1_valid  = 1'b0;
        in1_bcd    = '0;
        out1_ready = 1'b0;
        rst_n      = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].code, vecs[i].err);
        end

        // Backpressure: result held, new input ignored while DONE
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd4);
        in_bcd   = 16'h9999;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_code_c%0d", c), 32'(out_code), 32'h789A);
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_busy_c%0d", c), 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_next_latency", 32'(lat), 32'd4);
        chk("bp_next_code", 32'(out_code), 32'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of conversion
        in_bcd   = 16'h2899;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", 32'(out_code), 32'd0);
        chk("mid_rst_err", 32'(out_err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_no_valid", 32'(seen), 32'd0);
        run_word("post_rst", 16'h0000, 16'h6666, 4'b0000);

`ifdef BCD_EXCESS_DECODE_EN
        mode = 1'b1;
        run_word("dec_8EFF", 16'h8EFF, 16'h2899, 4'b0000);
        run_word("dec_5006", 16'h5006, 16'h0000, 4'b1110);
        mode = 1'b0;
`endif

        // Single-digit instance, OFFSET=3
        in1_bcd   = 4'h9;
        in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        chk("d1_busy", 32'(busy1), 32'd1);
        tick();
        chk("d1_valid", 32'(out1_valid), 32'd1);
        chk("d1_code", 32'(out1_code), 32'hC);
        chk("d1_err", 32'(out1_err), 32'd0);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        in1_bcd   = 4'hB;
        in1_valid = 1'b1;
        tick();
        in1_valid = 1'b0;
        tick();
        chk("d1b_valid", 32'(out1_valid), 32'd1);
        chk("d1b_code", 32'(out1_code), 32'h0);
        chk("d1b_err", 32'(out1_err), 32'd1);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
